// File: rtl/pcomp_table_if.sv
// Bus bundle between the position-table block and its controller: playback
// controls, table load strobes and the presented position with status.
interface pcomp_table_if #(
    parameter int AW = 9
);
    logic            enable_i;
    logic            next_i;
    logic            TABLE_RST;
    logic            TABLE_WSTB;
    logic [31:0]     TABLE_DATA;
    logic [31:0]     CYCLES;
    logic [63:0]     table_posn_o;
    logic            valid_o;
    logic            act_o;
    logic [1:0]      err_o;
    logic [AW:0]     table_len_o;

    modport master (
        output enable_i, next_i, TABLE_RST, TABLE_WSTB, TABLE_DATA, CYCLES,
        input  table_posn_o, valid_o, act_o, err_o, table_len_o
    );

    modport slave (
        input  enable_i, next_i, TABLE_RST, TABLE_WSTB, TABLE_DATA, CYCLES,
        output table_posn_o, valid_o, act_o, err_o, table_len_o
    );
endinterface

// File: rtl/pcomp_table.sv
// Software-loaded table of 64-bit compare positions, played back one entry per
// next_i strobe over a programmable number of passes.
module pcomp_table #(
    parameter int AW = 9
) (
    input  logic          clk_i,
    input  logic          reset_i,
    pcomp_table_if.slave  bus
);

    localparam int DEPTH = 2 ** AW;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_EMPTY = 2'd1;
    localparam logic [1:0] ERR_RST   = 2'd2;
    localparam logic [1:0] ERR_NEXT  = 2'd3;

    logic [63:0]   mem [DEPTH];
    logic [63:0]   rd_data_q;

    logic [31:0]   lo_q;
    logic          odd_q;
    logic [AW:0]   len_q;

    logic [1:0]    state_q;
    logic [AW-1:0] rd_ptr_q;
    logic [31:0]   pass_q;
    logic          en_q;
    logic [63:0]   posn_q;
    logic          valid_q;
    logic          act_q;
    logic [1:0]    err_q;

    logic          rise;
    logic          len_full;
    logic          wr_accept;
    logic          wr_entry;
    logic [AW:0]   rd_next;
    logic          more_entries;
    logic          wrap_ok;

    assign rise         = bus.enable_i & ~en_q;
    assign len_full     = len_q[AW];
    assign wr_accept    = bus.TABLE_WSTB & ~bus.TABLE_RST & ~act_q;
    // Only the second word of a pair commits an entry; a full table drops it.
    assign wr_entry     = wr_accept & odd_q & ~len_full;
    assign rd_next      = {1'b0, rd_ptr_q} + {{AW{1'b0}}, 1'b1};
    assign more_entries = (rd_next < len_q);
    assign wrap_ok      = (bus.CYCLES == 32'd0) || (pass_q < bus.CYCLES);

    assign bus.table_posn_o = posn_q;
    assign bus.valid_o      = valid_q;
    assign bus.act_o        = act_q;
    assign bus.err_o        = err_q;
    assign bus.table_len_o  = len_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lo_q  <= 32'd0;
            odd_q <= 1'b0;
            len_q <= '0;
        end else if (bus.TABLE_RST) begin
            odd_q <= 1'b0;
            len_q <= '0;
        end else if (wr_accept) begin
            if (!odd_q) begin
                lo_q  <= bus.TABLE_DATA;
                odd_q <= 1'b1;
            end else begin
                odd_q <= 1'b0;
                if (!len_full)
                    len_q <= len_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // NOTE: the table RAM and its read register have no reset so they map onto
    // block RAM; software reloads contents and len gates what is visible.
    always_ff @(posedge clk_i) begin
        if (wr_entry)
            mem[len_q[AW-1:0]] <= {bus.TABLE_DATA, lo_q};
        rd_data_q <= mem[rd_ptr_q];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            rd_ptr_q <= '0;
            pass_q   <= 32'd0;
            en_q     <= 1'b0;
            posn_q   <= 64'd0;
            valid_q  <= 1'b0;
            act_q    <= 1'b0;
            err_q    <= ERR_OK;
        end else begin
            en_q <= bus.enable_i;
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        if (len_q != '0) begin
                            rd_ptr_q <= '0;
                            pass_q   <= 32'd1;
                            err_q    <= ERR_OK;
                            act_q    <= 1'b1;
                            state_q  <= ST_FETCH;
                        end else begin
                            err_q <= ERR_EMPTY;
                        end
                    end
                end

                ST_FETCH: begin
                    if (bus.TABLE_RST) begin
                        err_q   <= ERR_RST;
                        act_q   <= 1'b0;
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!bus.enable_i) begin
                        act_q   <= 1'b0;
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (bus.next_i) begin
                        err_q   <= ERR_NEXT;
                        act_q   <= 1'b0;
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_READY;
                    end
                end

                ST_READY: begin
                    if (bus.TABLE_RST) begin
                        err_q   <= ERR_RST;
                        act_q   <= 1'b0;
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!bus.enable_i) begin
                        act_q   <= 1'b0;
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (bus.next_i) begin
                        valid_q <= 1'b0;
                        if (!valid_q) begin
                            // Advance requested before the entry was presented.
                            err_q   <= ERR_NEXT;
                            act_q   <= 1'b0;
                            state_q <= ST_IDLE;
                        end else if (more_entries) begin
                            rd_ptr_q <= rd_next[AW-1:0];
                            state_q  <= ST_FETCH;
                        end else if (wrap_ok) begin
                            rd_ptr_q <= '0;
                            pass_q   <= pass_q + 32'd1;
                            state_q  <= ST_FETCH;
                        end else begin
                            act_q   <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        // Read data settled during the first READY cycle.
                        valid_q <= 1'b1;
                        posn_q  <= rd_data_q;
                    end
                end

                default: begin
                    act_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcomp_table.sv
// Directed bench for pcomp_table: a vector table for load/playback sequences
// plus hand-written sequences for saturation, error codes and async reset.
module tb_pcomp_table;

    localparam int AW    = 9;
    localparam int DEPTH = 2 ** AW;

    typedef enum int {OP_NOP, OP_WR, OP_TRST, OP_START, OP_STOP, OP_NEXT, OP_CYC} op_e;

    typedef struct {
        op_e         op;
        logic [31:0] arg;
        int          waitc;
        bit          chk;
        logic        valid;
        logic        act;
        logic [1:0]  err;
        logic [9:0]  len;
        logic [63:0] posn;
    } vec_t;

    logic clk_i;
    logic reset_i;

    pcomp_table_if #(.AW(AW)) bus ();

    pcomp_table #(.AW(AW)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_word(input logic [31:0] d);
        bus.TABLE_WSTB = 1'b1;
        bus.TABLE_DATA = d;
        tick();
        bus.TABLE_WSTB = 1'b0;
    endtask

    task automatic pulse_trst();
        bus.TABLE_RST = 1'b1;
        tick();
        bus.TABLE_RST = 1'b0;
    endtask

    task automatic pulse_next();
        bus.next_i = 1'b1;
        tick();
        bus.next_i = 1'b0;
    endtask

    task automatic add(input op_e op, input logic [31:0] arg);
        vecs.push_back('{op, arg, 0, 1'b0, 1'b0, 1'b0, 2'd0, 10'd0, 64'd0});
    endtask

    task automatic expect_v(input op_e op, input logic [31:0] arg, input int waitc,
                            input logic v, input logic a, input logic [1:0] e,
                            input logic [9:0] l, input logic [63:0] p);
        vecs.push_back('{op, arg, waitc, 1'b1, v, a, e, l, p});
    endtask

    task automatic load_three();
        write_word(32'd100); write_word(32'd0);
        write_word(32'd200); write_word(32'd0);
        write_word(32'd300); write_word(32'd0);
    endtask

    task automatic check_outs(input string tag, input logic v, input logic a,
                              input logic [1:0] e, input logic [9:0] l, input logic [63:0] p);
        check({tag, ".valid"}, {63'd0, bus.valid_o}, {63'd0, v});
        check({tag, ".act"},   {63'd0, bus.act_o},   {63'd0, a});
        check({tag, ".err"},   {62'd0, bus.err_o},   {62'd0, e});
        check({tag, ".len"},   {54'd0, bus.table_len_o}, {54'd0, l});
        check({tag, ".posn"},  bus.table_posn_o, p);
    endtask

    initial begin
        reset_i        = 1'b1;
        bus.enable_i   = 1'b0;
        bus.next_i     = 1'b0;
        bus.TABLE_RST  = 1'b0;
        bus.TABLE_WSTB = 1'b0;
        bus.TABLE_DATA = 32'd0;
        bus.CYCLES     = 32'd0;

        // Reset state, then a three-entry table played once.
        expect_v(OP_NOP, 0, 0, 0, 0, 0, 0, 0);
        add(OP_WR, 100);
        expect_v(OP_WR, 0, 0, 0, 0, 0, 1, 0);
        add(OP_WR, 200); add(OP_WR, 0); add(OP_WR, 300);
        expect_v(OP_WR, 0, 0, 0, 0, 0, 3, 0);
        add(OP_CYC, 1);
        expect_v(OP_START, 0, 0, 0, 1, 0, 3, 0);
        expect_v(OP_NOP,   0, 1, 0, 1, 0, 3, 0);
        expect_v(OP_NOP,   0, 1, 1, 1, 0, 3, 100);
        expect_v(OP_NEXT,  0, 0, 0, 1, 0, 3, 100);
        expect_v(OP_NOP,   0, 9, 1, 1, 0, 3, 200);
        expect_v(OP_NEXT,  0, 10, 1, 1, 0, 3, 300);
        expect_v(OP_NEXT,  0, 0, 0, 0, 0, 3, 300);

        // Two passes.
        expect_v(OP_STOP, 0, 0, 0, 0, 0, 3, 300);
        add(OP_CYC, 2);
        expect_v(OP_START, 0, 2, 1, 1, 0, 3, 100);
        expect_v(OP_NEXT, 0, 2, 1, 1, 0, 3, 200);
        expect_v(OP_NEXT, 0, 2, 1, 1, 0, 3, 300);
        expect_v(OP_NEXT, 0, 2, 1, 1, 0, 3, 100);
        expect_v(OP_NEXT, 0, 2, 1, 1, 0, 3, 200);
        expect_v(OP_NEXT, 0, 2, 1, 1, 0, 3, 300);
        expect_v(OP_NEXT, 0, 0, 0, 0, 0, 3, 300);

        // Infinite passes, aborted by enable low.
        add(OP_STOP, 0);
        add(OP_CYC, 0);
        expect_v(OP_START, 0, 2, 1, 1, 0, 3, 100);
        expect_v(OP_NEXT, 0, 2, 1, 1, 0, 3, 200);
        expect_v(OP_NEXT, 0, 2, 1, 1, 0, 3, 300);
        expect_v(OP_NEXT, 0, 2, 1, 1, 0, 3, 100);
        expect_v(OP_NEXT, 0, 2, 1, 1, 0, 3, 200);
        expect_v(OP_NEXT, 0, 2, 1, 1, 0, 3, 300);
        expect_v(OP_NEXT, 0, 2, 1, 1, 0, 3, 100);
        expect_v(OP_NEXT, 0, 2, 1, 1, 0, 3, 200);
        expect_v(OP_STOP, 0, 0, 0, 0, 0, 3, 200);

        // Empty-table start, then an odd word count.
        expect_v(OP_TRST,  0, 0, 0, 0, 0, 0, 200);
        expect_v(OP_START, 0, 0, 0, 0, 1, 0, 200);
        expect_v(OP_NOP,   0, 3, 0, 0, 1, 0, 200);
        add(OP_STOP, 0);
        add(OP_WR, 1); add(OP_WR, 2); add(OP_WR, 3);
        expect_v(OP_WR, 4, 0, 0, 0, 1, 2, 200);
        expect_v(OP_WR, 5, 0, 0, 0, 1, 2, 200);
        add(OP_CYC, 1);
        expect_v(OP_START, 0, 2, 1, 1, 0, 2, 64'h00000002_00000001);
        expect_v(OP_NEXT,  0, 2, 1, 1, 0, 2, 64'h00000004_00000003);
        expect_v(OP_NEXT,  0, 0, 0, 0, 0, 2, 64'h00000004_00000003);
        add(OP_STOP, 0);

        #22;
        reset_i = 1'b0;
        tick();

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_WR:    write_word(vecs[i].arg);
                OP_TRST:  pulse_trst();
                OP_START: begin bus.enable_i = 1'b1; tick(); end
                OP_STOP:  begin bus.enable_i = 1'b0; tick(); end
                OP_NEXT:  pulse_next();
                OP_CYC:   bus.CYCLES = vecs[i].arg;
                default:  ;
            endcase
            for (int w = 0; w < vecs[i].waitc; w++) tick();
            if (vecs[i].chk)
                check_outs($sformatf("v%0d", i), vecs[i].valid, vecs[i].act,
                           vecs[i].err, vecs[i].len, vecs[i].posn);
        end

        // Overfill: 2*DEPTH+2 words saturate len and must not overwrite entry 0.
        pulse_trst();
        for (int i = 0; i < 2 * DEPTH + 2; i++) write_word(i[31:0]);
        check("fill.len", {54'd0, bus.table_len_o}, 64'(DEPTH));
        bus.CYCLES = 32'd1;
        bus.enable_i = 1'b1;
        tick(); tick(); tick();
        check("fill.e0", bus.table_posn_o, 64'h00000001_00000000);
        pulse_next(); tick(); tick();
        check("fill.e1", bus.table_posn_o, 64'h00000003_00000002);
        bus.enable_i = 1'b0;
        tick();

        // Writes during play are ignored.
        pulse_trst();
        load_three();
        check("reload.len", {54'd0, bus.table_len_o}, 64'd3);
        bus.CYCLES = 32'd0;
        bus.enable_i = 1'b1;
        tick(); tick(); tick();
        check_outs("play", 1, 1, 0, 3, 100);
        write_word(32'd77); write_word(32'd78);
        tick();
        check("wr_in_play.len", {54'd0, bus.table_len_o}, 64'd3);

        // next_i on the cycle right after an accepted next_i.
        bus.next_i = 1'b1;
        tick(); tick();
        bus.next_i = 1'b0;
        check("dbl_next.err", {62'd0, bus.err_o}, 64'd3);
        check("dbl_next.act", {63'd0, bus.act_o}, 64'd0);
        check("dbl_next.valid", {63'd0, bus.valid_o}, 64'd0);

        // Restart clears the error.
        bus.enable_i = 1'b0; tick();
        bus.enable_i = 1'b1; tick();
        check("restart.err", {62'd0, bus.err_o}, 64'd0);
        check("restart.act", {63'd0, bus.act_o}, 64'd1);
        tick(); tick();
        check("restart.posn", bus.table_posn_o, 64'd100);

        // TABLE_RST while READY.
        pulse_trst();
        check("trst_play.err", {62'd0, bus.err_o}, 64'd2);
        check("trst_play.act", {63'd0, bus.act_o}, 64'd0);
        check("trst_play.len", {54'd0, bus.table_len_o}, 64'd0);
        check("trst_play.valid", {63'd0, bus.valid_o}, 64'd0);

        // Asynchronous reset mid-play, asserted between clock edges.
        load_three();
        bus.enable_i = 1'b0; tick();
        bus.enable_i = 1'b1; tick(); tick(); tick();
        pulse_next(); tick(); tick();
        check("pre_rst.posn", bus.table_posn_o, 64'd200);
        #2;
        reset_i = 1'b1;
        #1;
        check_outs("async_rst", 0, 0, 0, 0, 0);
        bus.enable_i = 1'b0;
        #2;
        reset_i = 1'b0;
        tick();
        check_outs("post_rst", 0, 0, 0, 0, 0);
        write_word(32'd500); write_word(32'd0);
        bus.enable_i = 1'b1;
        tick(); tick(); tick();
        check_outs("post_rst_play", 1, 1, 0, 1, 500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pcomp_table.md
Name: pcomp_table

Overview:
- Upstream position source for the position-compare block.
- Holds a software-loaded table of 64-bit compare positions and presents the current entry on table_posn_o, which feeds the compare block's table_posn_i when its USE_TABLE is set.
- Advances one entry per next_i strobe, driven by the compare block's pulse output.
- Supports repeated passes over the table, with a status code for misuse.

Parameters:
AW, 9, log2 of table depth in 64-bit entries (DEPTH = 2**AW).

Ports:
clk_i  in  1  system clock
reset_i  in  1  reset, asynchronous, active-high
enable_i  in  1  playback gate; a rising edge starts playback, a low level aborts it
next_i  in  1  single-cycle advance strobe
TABLE_RST  in  1  strobe; clears table contents and length
TABLE_WSTB  in  1  strobe; write TABLE_DATA
TABLE_DATA  in  32  table word, low half of each entry written first
CYCLES  in  32  number of passes over the table; 0 = infinite
table_posn_o  out  64  current entry
valid_o  out  1  table_posn_o is valid
act_o  out  1  playback active
err_o  out  2  status: 0 ok, 1 empty table at start, 2 TABLE_RST while active, 3 next_i while not valid
table_len_o  out  AW+1  number of complete entries loaded

Behaviour:
- Reset (reset_i=1, asynchronous) sets all outputs to 0, write pointer 0, length 0, FSM to IDLE. Memory contents are not reset.
- Load path:
  - Word write with TABLE_WSTB: even word latched into low holding register; odd word writes {TABLE_DATA, low} to mem[len] and len increments.
  - table_len_o updates the cycle after the odd write.
  - A trailing odd word is never counted.
  - At len = DEPTH, further writes are dropped and len saturates.
  - Writes are ignored while act_o=1.
- TABLE_RST clears the word pointer and len the next cycle. TABLE_RST and TABLE_WSTB in the same cycle: reset wins, write dropped.
- Memory is single-port write / registered read, 1-cycle read latency, 64 bits wide.
- Rising edge = enable_i=1 with the registered previous sample = 0.
- FSM states:
  - IDLE: act_o=0, valid_o=0.
    - Rising edge with len>0: rd_ptr=0, pass=1, err_o=0, go to FETCH.
    - Rising edge with len=0: err_o=1, stay IDLE.
    - next_i ignored.
  - FETCH: present rd_ptr to memory; go to READY next cycle.
  - READY: valid_o=1, table_posn_o = mem[rd_ptr].
    - On next_i: valid_o=0 next cycle.
    - If rd_ptr+1 < len: rd_ptr++, go to FETCH.
    - Else if CYCLES=0 or pass < CYCLES: rd_ptr=0, pass++, go to FETCH.
    - Else go to IDLE (normal completion, err_o stays 0).
- Latency:
  - Rising edge sampled at edge T: act_o=1 after T; valid_o=1 and posn valid after T+2.
  - next_i sampled at edge N: valid_o=0 after N, new posn valid after N+2.
- Errors and aborts:
  - next_i in FETCH: err_o=3, go to IDLE.
  - enable_i=0 in FETCH/READY: go to IDLE next cycle, err_o unchanged.
  - TABLE_RST in FETCH/READY: err_o=2, go to IDLE, len cleared.
- err_o holds until the next successful start or reset.
- table_posn_o holds its last value when valid_o=0.
- pass counter is 32-bit and compared unsigned; no wrap is possible before CYCLES is reached.
- CYCLES is sampled continuously; changing it mid-play affects the next wrap decision.

Test Plan:
1. Write words 100,0,200,0,300,0; CYCLES=1; enable rises at edge T -> table_len_o=3; act_o=1 after T; valid_o=1 with posn=100 after T+2. Three next_i strobes spaced 10 cycles -> posn 200, then 300, then act_o=0 and valid_o=0 one cycle after the third strobe; err_o=0.
2. Same table, CYCLES=2 -> posn sequence 100,200,300,100,200,300 across five strobes; act_o=0 after the sixth strobe.
3. CYCLES=0, seven strobes -> posn=200, act_o=1. Then enable_i=0 -> act_o=0 next cycle, err_o=0.
4. Length handling:
   - TABLE_RST, then enable -> err_o=1, act_o=0.
   - Write 5 words (1,2,3,4,5) -> table_len_o=2, posn entries 0x00000002_00000001 and 0x00000004_00000003.
   - Writing 2*DEPTH+2 words -> table_len_o=DEPTH.
5. Error codes and writes during play:
   - next_i on the cycle immediately after an accepted next_i -> err_o=3, act_o=0.
   - Restart -> err_o=0.
   - TABLE_WSTB during play -> table_len_o unchanged.
6. TABLE_RST while READY -> err_o=2, act_o=0, table_len_o=0. reset_i pulsed mid-play, asynchronously between edges -> all outputs 0 immediately; FSM in IDLE afterwards.
